// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package fetch_unit_pkg;

   localparam int DEFAULT_ADDR_WIDTH   = 32;
   localparam int DEFAULT_DATA_WIDTH   = 32;
   localparam int DEFAULT_READ_LATENCY = 1;
   localparam int DEFAULT_FIFO_DEPTH   = 4;

   // Latency counter counts 0..READ_LATENCY-1, READ_LATENCY is at most 15.
   localparam int LAT_WIDTH = 4;

   // ISSUE: address on the bus, latency counter running.
   // FULL : read finished into a full buffer, address held until space frees.
   typedef enum logic {
      ST_ISSUE = 1'b0,
      ST_FULL  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small output buffer for fetched {address, data} words: synchronous
// push/pop/flush, combinational head read, count output.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wr_data,
   output logic [WIDTH-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;

   // Pointer and occupancy bookkeeping; flush empties the buffer outright.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage write; contents need no reset because the head is gated by count.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_reg] <= wr_data;
   end

   assign rd_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
   assign count   = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Sequential word fetcher: presents an address to memory for READ_LATENCY
// cycles, captures the returned word into an output buffer, and restarts
// from a new address on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
   parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int                    READ_LATENCY  = DEFAULT_READ_LATENCY,
   parameter int                    FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_address,
   output logic [ADDR_WIDTH-1:0] memory_address,
   input  logic [DATA_WIDTH-1:0] memory_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_address
);

   localparam int                   CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LAT_WIDTH-1:0] LAT_LAST  = LAT_WIDTH'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   fetch_state_t          state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [LAT_WIDTH-1:0]  lat_reg, lat_next;

   logic [CNT_W-1:0]                 fifo_count;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_rd_data;
   logic                             read_done;
   logic                             not_full;
   logic                             push;
   logic                             pop;

   // A read completes on the last cycle of the latency window; it is only
   // captured if the buffer has room before any same-edge pop.
   assign read_done = (state_reg == ST_ISSUE) && (lat_reg == LAT_LAST);
   assign not_full  = (fifo_count < DEPTH_CNT);
   assign push      = read_done && not_full && !redirect_valid;
   assign pop       = out_valid && out_ready && !redirect_valid;

   // State, fetch address and latency counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_ISSUE;
         addr_reg  <= RESET_ADDRESS;
         lat_reg   <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         lat_reg   <= lat_next;
      end
   end

   // Next-state logic; redirect overrides everything else.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      lat_next   = lat_reg;
      if (redirect_valid) begin
         state_next = ST_ISSUE;
         addr_next  = redirect_address;
         lat_next   = '0;
      end else begin
         case (state_reg)
            ST_ISSUE: begin
               if (read_done) begin
                  lat_next = '0;
                  if (not_full) addr_next  = addr_reg + ADDR_WIDTH'(1);
                  else          state_next = ST_FULL;
               end else begin
                  lat_next = lat_reg + LAT_WIDTH'(1);
               end
            end
            ST_FULL: begin
               // The read is repeated in full once space appears.
               lat_next = '0;
               if (not_full) state_next = ST_ISSUE;
            end
            default: state_next = ST_ISSUE;
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR_WIDTH + DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (redirect_valid),
      .push    (push),
      .pop     (pop),
      .wr_data ({addr_reg, memory_data}),
      .rd_data (fifo_rd_data),
      .count   (fifo_count)
   );

   assign memory_address = addr_reg;
   assign out_valid      = (fifo_count != '0);
   assign out_address    = fifo_rd_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
   assign out_data       = fifo_rd_data[DATA_WIDTH-1:0];

endmodule
